// File: rtl/carfield_pkg.sv
// Shared Carfield terminator types: AXI response codes, error-slave
// FSM states and the default AXI4 request/response bundles.
package carfield_pkg;

    localparam int unsigned AXI_ID_W   = 6;
    localparam int unsigned AXI_ADDR_W = 48;
    localparam int unsigned AXI_DATA_W = 64;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } err_wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } err_rd_state_e;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [5:0]            atop;
    } axi_aw_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        logic [AXI_STRB_W-1:0] strb;
        logic                  last;
    } axi_w_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [1:0]          resp;
    } axi_b_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
    } axi_ar_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } axi_r_t;

    typedef struct packed {
        axi_aw_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ar_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        axi_b_t b;
        logic   b_valid;
        axi_r_t r;
        logic   r_valid;
    } axi_rsp_t;

endpackage

// File: rtl/carfield_island_err_slave_if.sv
// AXI4 request/response bundle between a crossbar (master) and a
// terminator (slave). Ports: req (master->slave), rsp (slave->master).
interface carfield_island_err_slave_if;
    import carfield_pkg::*;

    axi_req_t req;
    axi_rsp_t rsp;

    modport master (output req, input rsp);
    modport slave  (input req, output rsp);

endinterface

// File: rtl/carfield_island_err_rd.sv
// Read path of the island error slave: accepts one AR, then streams
// len+1 beats. Ports: AR handshake in, R valid/id/last out, busy out.
module carfield_island_err_rd #(
    parameter int unsigned IdWidth = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ar_valid_i,
    input  logic [IdWidth-1:0] ar_id_i,
    input  logic [7:0]         ar_len_i,
    input  logic               r_ready_i,
    output logic               ar_ready_o,
    output logic               r_valid_o,
    output logic [IdWidth-1:0] r_id_o,
    output logic               r_last_o,
    output logic               busy_o
);
    import carfield_pkg::*;

    err_rd_state_e      state_d, state_q;
    logic [IdWidth-1:0] id_d, id_q;
    logic [7:0]         beats_d, beats_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= R_IDLE;
            id_q    <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            beats_q <= beats_d;
        end
    end

    // beats_q counts remaining beats after the current one, so the
    // last beat is at zero and the counter never wraps.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        beats_d = beats_q;
        case (state_q)
            R_IDLE: begin
                if (ar_valid_i) begin
                    id_d    = ar_id_i;
                    beats_d = ar_len_i;
                    state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_ready_i) begin
                    if (beats_q == 8'd0) begin
                        state_d = R_IDLE;
                    end else begin
                        beats_d = beats_q - 8'd1;
                    end
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    assign ar_ready_o = (state_q == R_IDLE);
    assign r_valid_o  = (state_q == R_DATA);
    assign r_id_o     = id_q;
    assign r_last_o   = r_valid_o && (beats_q == 8'd0);
    assign busy_o     = (state_q != R_IDLE);

endmodule

// File: rtl/carfield_island_err_slave.sv
// AXI4 terminator for disabled islands: sinks writes, returns fixed
// read data, errors every response. Ports: clk_i, rst_i, axi_req_i,
// axi_rsp_o, busy_o.
module carfield_island_err_slave #(
    parameter int unsigned AxiIdWidth   = carfield_pkg::AXI_ID_W,
    parameter int unsigned AxiDataWidth = carfield_pkg::AXI_DATA_W,
    parameter logic [63:0] RespData     = 64'hCA7F_1E1D_DEAD_BEEF,
    parameter logic [1:0]  RespCode     = 2'b11,
    parameter type         axi_req_t    = carfield_pkg::axi_req_t,
    parameter type         axi_rsp_t    = carfield_pkg::axi_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  axi_req_t axi_req_i,
    output axi_rsp_t axi_rsp_o,
    output logic     busy_o
);
    import carfield_pkg::*;

    err_wr_state_e         wr_state_d, wr_state_q;
    logic [AxiIdWidth-1:0] wr_id_d, wr_id_q;

    logic                  rd_ar_ready;
    logic                  rd_r_valid;
    logic [AxiIdWidth-1:0] rd_r_id;
    logic                  rd_r_last;
    logic                  rd_busy;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_state_q <= W_IDLE;
            wr_id_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_id_q    <= wr_id_d;
        end
    end

    // Readies are pure functions of state, so valid alone marks a
    // handshake in the matching state.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_id_d    = wr_id_q;
        case (wr_state_q)
            W_IDLE: begin
                if (axi_req_i.aw_valid) begin
                    wr_id_d    = axi_req_i.aw.id;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (axi_req_i.w_valid && axi_req_i.w.last) begin
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (axi_req_i.b_ready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    carfield_island_err_rd #(
        .IdWidth (AxiIdWidth)
    ) i_rd (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ar_valid_i (axi_req_i.ar_valid),
        .ar_id_i    (axi_req_i.ar.id),
        .ar_len_i   (axi_req_i.ar.len),
        .r_ready_i  (axi_req_i.r_ready),
        .ar_ready_o (rd_ar_ready),
        .r_valid_o  (rd_r_valid),
        .r_id_o     (rd_r_id),
        .r_last_o   (rd_r_last),
        .busy_o     (rd_busy)
    );

    // State resets to IDLE, whose readies are high; reset masks them
    // so the crossbar sees a silent port while rst_i is held.
    always_comb begin
        axi_rsp_o = '0;
        if (!rst_i) begin
            axi_rsp_o.aw_ready = (wr_state_q == W_IDLE);
            axi_rsp_o.w_ready  = (wr_state_q == W_DATA);
            axi_rsp_o.b_valid  = (wr_state_q == W_RESP);
            axi_rsp_o.b.id     = wr_id_q;
            axi_rsp_o.b.resp   = RespCode;
            axi_rsp_o.ar_ready = rd_ar_ready;
            axi_rsp_o.r_valid  = rd_r_valid;
            axi_rsp_o.r.id     = rd_r_id;
            axi_rsp_o.r.data   = RespData[AxiDataWidth-1:0];
            axi_rsp_o.r.resp   = RespCode;
            axi_rsp_o.r.last   = rd_r_last;
        end
    end

    assign busy_o = !rst_i && ((wr_state_q != W_IDLE) || rd_busy);

    logic unused_req;
    assign unused_req = ^{
        axi_req_i.aw.addr, axi_req_i.aw.len,
        axi_req_i.aw.size, axi_req_i.aw.burst,
        axi_req_i.aw.lock, axi_req_i.aw.cache,
        axi_req_i.aw.prot, axi_req_i.aw.atop,
        axi_req_i.w.data, axi_req_i.w.strb,
        axi_req_i.ar.addr, axi_req_i.ar.size,
        axi_req_i.ar.burst, axi_req_i.ar.lock,
        axi_req_i.ar.cache, axi_req_i.ar.prot
    };

endmodule

// File: tb/tb_carfield_island_err_slave.sv
// Scoreboard bench for carfield_island_err_slave: stimulus queues
// expected B/R responses, a negedge monitor pops and compares them.
module tb_carfield_island_err_slave;
    import carfield_pkg::*;

    localparam logic [63:0] RDATA = 64'hCA7F_1E1D_DEAD_BEEF;
    localparam logic [1:0]  RCODE = 2'b11;

    typedef struct {
        logic [5:0] id;
        logic       last;
    } rexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    int total = 0;
    int bad   = 0;

    logic [5:0] bq[$];
    rexp_t      rq[$];

    carfield_island_err_slave_if bus ();

    carfield_island_err_slave #(
        .RespCode (RCODE)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .axi_req_i (bus.req),
        .axi_rsp_o (bus.rsp),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every B/R handshake against the scoreboard and
    // checks that a stalled R beat holds its payload.
    logic [5:0]  bexp_m;
    rexp_t       rexp_m;
    logic        stall_q = 1'b0;
    logic [73:0] held_q;

    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (bus.rsp.b_valid && bus.req.b_ready) begin
                if (bq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL b_unexpected: id %0h", bus.rsp.b.id);
                end else begin
                    bexp_m = bq.pop_front();
                    chk("b_id", bus.rsp.b.id, bexp_m);
                    chk("b_resp", bus.rsp.b.resp, RCODE);
                end
            end
            if (bus.rsp.r_valid && bus.req.r_ready) begin
                if (rq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL r_unexpected: id %0h", bus.rsp.r.id);
                end else begin
                    rexp_m = rq.pop_front();
                    chk("r_id", bus.rsp.r.id, rexp_m.id);
                    chk("r_data", bus.rsp.r.data, RDATA);
                    chk("r_resp", bus.rsp.r.resp, RCODE);
                    chk("r_last", bus.rsp.r.last, rexp_m.last);
                end
            end
            if (stall_q) begin
                chk("r_stable", {bus.rsp.r_valid, bus.rsp.r}, held_q);
            end
            stall_q = bus.rsp.r_valid && !bus.req.r_ready;
            held_q  = {bus.rsp.r_valid, bus.rsp.r};
        end
    end

    task automatic do_write(input logic [5:0] wid, input int nbeats,
                            input int early);
        int cnt = 0;
        int cyc = 0;
        bq.push_back(wid);
        bus.req.w_valid   = (early > 0);
        bus.req.w.last    = (nbeats == 1);
        bus.req.w.data    = 64'h1234;
        for (int i = 0; i < early; i++) begin
            @(negedge clk);
            chk("w_ready_early", bus.rsp.w_ready, 1'b0);
            step();
        end
        bus.req.aw_valid = 1'b1;
        bus.req.aw.id    = wid;
        bus.req.aw.len   = 8'(nbeats - 1);
        @(negedge clk);
        chk("aw_ready_idle", bus.rsp.aw_ready, 1'b1);
        chk("w_ready_pre_aw", bus.rsp.w_ready, 1'b0);
        step();
        bus.req.aw_valid = 1'b0;
        bus.req.w_valid  = 1'b1;
        while (cnt < nbeats && cyc < 200) begin
            bus.req.w.last = (cnt == nbeats - 1);
            bus.req.w.data = 64'h1234 + 64'(cnt);
            @(negedge clk);
            if (cyc == 0) begin
                chk("w_ready_after_aw", bus.rsp.w_ready, 1'b1);
                chk("aw_ready_busy", bus.rsp.aw_ready, 1'b0);
            end
            chk("b_early", bus.rsp.b_valid, 1'b0);
            if (bus.req.w_valid && bus.rsp.w_ready) cnt++;
            cyc++;
            step();
        end
        chk("w_beats", cnt, nbeats);
        chk("w_cycles", cyc, nbeats);
        bus.req.w_valid = 1'b0;
        bus.req.w.last  = 1'b0;
        bus.req.b_ready = 1'b1;
        @(negedge clk);
        chk("b_latency", bus.rsp.b_valid, 1'b1);
        step();
        bus.req.b_ready = 1'b0;
        @(negedge clk);
        chk("aw_ready_after_b", bus.rsp.aw_ready, 1'b1);
        chk("b_done", bus.rsp.b_valid, 1'b0);
        step();
    endtask

    task automatic do_read(input logic [5:0] rid, input int len,
                           input bit rnd);
        int cnt = 0;
        int cyc = 0;
        for (int i = 0; i <= len; i++) begin
            rq.push_back('{id: rid, last: (i == len)});
        end
        bus.req.ar_valid = 1'b1;
        bus.req.ar.id    = rid;
        bus.req.ar.len   = 8'(len);
        @(negedge clk);
        chk("ar_ready_idle", bus.rsp.ar_ready, 1'b1);
        step();
        bus.req.ar_valid = 1'b0;
        while (cnt <= len && cyc < 3000) begin
            bus.req.r_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (cyc == 0) begin
                chk("r_first", bus.rsp.r_valid, 1'b1);
                chk("ar_ready_busy", bus.rsp.ar_ready, 1'b0);
            end
            if (bus.rsp.r_valid && bus.req.r_ready) cnt++;
            cyc++;
            step();
        end
        chk("r_beats", cnt, len + 1);
        if (!rnd) chk("r_cycles", cyc, len + 1);
        bus.req.r_ready = 1'b0;
        @(negedge clk);
        chk("ar_ready_after_r", bus.rsp.ar_ready, 1'b1);
        chk("r_idle", bus.rsp.r_valid, 1'b0);
        step();
    endtask

    initial begin
        bus.req = '0;
        rst     = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_rsp", bus.rsp, '0);
        chk("rst_busy", busy, 1'b0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_aw_ready", bus.rsp.aw_ready, 1'b1);
        chk("post_rst_ar_ready", bus.rsp.ar_ready, 1'b1);
        step();

        do_write(6'd5, 1, 0);
        do_read(6'd3, 3, 1'b0);
        do_read(6'd9, 255, 1'b1);

        // Same-cycle AW and AR; read completes while write pends.
        bq.push_back(6'd1);
        rq.push_back('{id: 6'd2, last: 1'b1});
        bus.req.aw_valid = 1'b1;
        bus.req.aw.id    = 6'd1;
        bus.req.aw.len   = 8'd1;
        bus.req.ar_valid = 1'b1;
        bus.req.ar.id    = 6'd2;
        bus.req.ar.len   = 8'd0;
        @(negedge clk);
        chk("cc_aw_ready", bus.rsp.aw_ready, 1'b1);
        chk("cc_ar_ready", bus.rsp.ar_ready, 1'b1);
        step();
        bus.req.aw_valid = 1'b0;
        bus.req.ar_valid = 1'b0;
        bus.req.r_ready  = 1'b1;
        bus.req.w_valid  = 1'b1;
        bus.req.w.last   = 1'b0;
        @(negedge clk);
        chk("cc_r_valid", bus.rsp.r_valid, 1'b1);
        chk("cc_w_ready", bus.rsp.w_ready, 1'b1);
        chk("cc_busy", busy, 1'b1);
        step();
        bus.req.w.last = 1'b1;
        @(negedge clk);
        chk("cc_r_done", bus.rsp.r_valid, 1'b0);
        chk("cc_b_wait", bus.rsp.b_valid, 1'b0);
        step();
        bus.req.w_valid = 1'b0;
        bus.req.w.last  = 1'b0;
        bus.req.b_ready = 1'b1;
        bus.req.r_ready = 1'b0;
        @(negedge clk);
        chk("cc_b_valid", bus.rsp.b_valid, 1'b1);
        step();
        bus.req.b_ready = 1'b0;
        @(negedge clk);
        chk("cc_aw_ready_back", bus.rsp.aw_ready, 1'b1);
        chk("cc_idle", busy, 1'b0);
        step();

        do_write(6'd6, 2, 4);

        // Reset pulse in the middle of a len=7 read burst.
        for (int i = 0; i < 8; i++) begin
            rq.push_back('{id: 6'd7, last: (i == 7)});
        end
        bus.req.ar_valid = 1'b1;
        bus.req.ar.id    = 6'd7;
        bus.req.ar.len   = 8'd7;
        step();
        bus.req.ar_valid = 1'b0;
        bus.req.r_ready  = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        rq.delete();
        @(negedge clk);
        chk("mid_rst_rsp", bus.rsp, '0);
        chk("mid_rst_busy", busy, 1'b0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ar_ready", bus.rsp.ar_ready, 1'b1);
        chk("rst_r_valid", bus.rsp.r_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            chk("no_r_after_rst", bus.rsp.r_valid, 1'b0);
        end
        bus.req.r_ready = 1'b0;
        step();

        do_read(6'd4, 0, 1'b0);

        chk("bq_empty", bq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/carfield_island_err_slave.md
# carfield_island_err_slave

AXI4 subordinate that terminates every transaction addressed to an island or peripheral window whose enable flag is cleared in the Carfield configuration, so no host access ever hangs. The system crossbar routes the window to this block in place of the missing island. It fully accepts write bursts and issues read bursts of the requested length with a fixed data pattern. Every transaction completes with a configurable error response.

## Interface
- `AxiIdWidth`, 6: width of the AW/AR/B/R id fields.
- `AxiDataWidth`, 64: width of the R data field.
- `RespData`, 64'hCA7F_1E1D_DEAD_BEEF: read data returned on every beat, truncated to `AxiDataWidth`.
- `RespCode`, 2'b11: resp field on every B and R beat (DECERR; 2'b10 selects SLVERR).
- `axi_req_t`, logic: AXI4 request struct (aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready).
- `axi_rsp_t`, logic: AXI4 response struct (aw_ready, ar_ready, w_ready, b, b_valid, r, r_valid).
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `axi_req_i`  in  `axi_req_t`  AXI4 request from the crossbar.
- `axi_rsp_o`  out  `axi_rsp_t`  AXI4 response to the crossbar.
- `busy_o`  out  1  high while either path is outside IDLE.

## Operation
- Write and read paths are independent FSMs. Each path has at most one transaction outstanding.
- Write FSM: W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: aw_ready=1. On the AW handshake, latch aw.id and go to W_DATA. aw.addr, len, size, burst, atop, cache and prot are ignored.
  - W_DATA: w_ready=1 and every beat is discarded. On a W handshake with w.last=1, go to W_RESP.
  - W_RESP: b_valid=1, b.id = latched id, b.resp = `RespCode`. On b_ready, go to W_IDLE.
- The write path never raises w_ready before the AW handshake. Early W beats stall, which is legal AXI.
- Write beat count is not checked against aw.len. Termination is by w.last only.
- Read FSM: R_IDLE → R_DATA → R_IDLE.
  - R_IDLE: ar_ready=1. On the AR handshake, latch ar.id and load the 8-bit counter `beats_q` ← ar.len, then go to R_DATA.
  - R_DATA: r_valid=1, r.id = latched id, r.data = `RespData`, r.resp = `RespCode`, r.last = (`beats_q`==0).
  - On each R handshake in R_DATA: if `beats_q`==0, go to R_IDLE; otherwise decrement `beats_q`.
- ar.len=255 yields exactly 256 beats. The counter never wraps.
- r_valid holds, with stable payload, until r_ready.
- AW and AR handshakes in the same cycle are both accepted. The two paths never block each other.
- Reset asserted mid-burst: both FSMs return to IDLE on that edge. The partial burst is abandoned and produces no B or R.

## Timing
- All `axi_rsp_o` fields and `busy_o` are driven from registers or from registered state only. No combinational path exists from `axi_req_i` to `axi_rsp_o`.
- While `rst_i`=1, every output is 0. In the first cycle after `rst_i` falls, aw_ready=1 and ar_ready=1.
- AW handshake at cycle t: aw_ready=0 and w_ready=1 from t+1.
- Last W handshake at t: b_valid=1 at t+1.
- B handshake at t: aw_ready=1 at t+1.
- AR handshake at t: first r_valid at t+1. With r_ready held at 1, one beat per cycle, so the last beat is at t+1+len.
- Last R handshake at t: ar_ready=1 at t+1.
- Minimum back-to-back spacing:
  - Single-beat write: 3 cycles.
  - Single-beat read: 2 cycles.

## Structure
- `carfield_pkg` holds the following, shared with other Carfield terminators:
  - the `axi_resp_e` encodings (OKAY/EXOKAY/SLVERR/DECERR);
  - the `err_wr_state_e` enum (W_IDLE, W_DATA, W_RESP);
  - the `err_rd_state_e` enum (R_IDLE, R_DATA).
- One sub-module, `carfield_island_err_rd`, holds the read FSM and beat counter. The write FSM stays in the top.

## Test plan
- Single write, id=5, len=0, data 64'h1234 → b_valid at t+1 after the wlast handshake with b.id=5 and b.resp=2'b11; aw_ready returns 1 the cycle after the B handshake.
- Read, id=3, len=3, r_ready=1 → exactly 4 beats on consecutive cycles, each r.data=`RespData` and r.resp=2'b11, with r.last only on beat 4.
- Read with len=255 and r_ready toggled 50% at random → 256 beats with stable payload while stalled; r.last only on beat 256; `beats_q` never underflows.
- Same-cycle AW (id=1, len=1) and AR (id=2, len=0) → both accepted in the same cycle; R for id 2 completes while W is pending; B for id 1 follows its wlast.
- W beats presented 4 cycles before AW → w_ready stays 0 until the cycle after the AW handshake; no beat is lost or double-counted.
- `rst_i` pulsed for 1 cycle during R_DATA of a len=7 burst → all outputs 0 during reset; no further R beats; ar_ready=1 the cycle after reset.
